// File: rtl/usb_rx_line.sv
// usb_rx_line: full-speed USB receive front-end (bit recovery, NRZI, SYNC, destuff, EOP).
// Define USB_RX_BUS_RESET_EN to build the long-SE0 bus-reset detector.
module usb_rx_line #(
    parameter int SYNC_TIMEOUT = 16,
    parameter int IDLE_RECOVER = 8,
    parameter int RESET_CYCLES = 120
) (
    input  logic       clock48,
    input  logic       reset,
    input  logic       usb_d_p,
    input  logic       usb_d_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       bus_reset
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} state_t;
    localparam logic [1:0] LS_J = 2'b10;
    localparam logic [1:0] LS_K = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int RW = $clog2(IDLE_RECOVER + 1);
    localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_TIMEOUT - 1);
    localparam logic [RW-1:0] REC_LAST = RW'(IDLE_RECOVER - 1);

    state_t state_q, state_d;
    logic [1:0] sync1_q, line_q, phase_q;
    logic prev_q, prev_d, eop2_q, eop2_d, part_q, part_d;
    logic [7:0] sr_q, sr_d, data_q, data_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] jcnt_q, jcnt_d;
    logic [2:0] bits_q, bits_d, ones_q, ones_d;
    logic valid_q, valid_d, active_q, active_d, eop_q, eop_d, err_q, err_d;
    logic smp, bit_v, br_d;

    assign smp = phase_q == 2'd2;
    assign bit_v = line_q[1] == prev_q;

`ifdef USB_RX_BUS_RESET_EN
    localparam int SW = $clog2(RESET_CYCLES + 1);
    localparam logic [SW-1:0] SE0_MAX = SW'(RESET_CYCLES);
    logic [SW-1:0] se0_q;
    logic br_q;
    assign br_d = (line_q == LS_SE0) && (se0_q >= SE0_MAX - 1'b1);
    always_ff @(posedge clock48) begin
        if (reset) begin
            se0_q <= '0;
            br_q  <= 1'b0;
        end else begin
            se0_q <= (line_q != LS_SE0) ? '0 : ((se0_q == SE0_MAX) ? se0_q : se0_q + 1'b1);
            br_q  <= br_d;
        end
    end
    assign bus_reset = br_q;
`else
    // detector absent: never forces IDLE
    assign br_d = RESET_CYCLES < 0;
    assign bus_reset = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        prev_d = prev_q;
        sr_d = sr_q;
        cnt_d = cnt_q;
        bits_d = bits_q;
        ones_d = ones_q;
        eop2_d = eop2_q;
        part_d = part_q;
        jcnt_d = jcnt_q;
        data_d = data_q;
        active_d = active_q;
        valid_d = 1'b0;
        eop_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (line_q == LS_K) begin
                state_d = SYNC;
                prev_d = 1'b1;
                sr_d = '0;
                cnt_d = '0;
            end
            SYNC: if (smp) begin
                prev_d = line_q[1];
                sr_d = {bit_v, sr_q[7:1]};
                cnt_d = cnt_q + 1'b1;
                if (sr_d == 8'h80) begin
                    state_d = DATA;
                    active_d = 1'b1;
                    bits_d = '0;
                    ones_d = '0;
                end else if (cnt_q == SYNC_LAST) state_d = ERR;
            end
            DATA: if (smp) begin
                if (line_q == LS_SE0) begin
                    state_d = EOP;
                    eop2_d = 1'b0;
                    part_d = bits_q != 3'd0;
                end else if (line_q == LS_SE1) state_d = ERR;
                else begin
                    prev_d = line_q[1];
                    // after six ones the sample is a stuff bit: a 0 is dropped, a 1 is illegal
                    if (ones_q == 3'd6) begin
                        ones_d = '0;
                        state_d = bit_v ? ERR : DATA;
                    end else begin
                        ones_d = bit_v ? ones_q + 3'd1 : 3'd0;
                        sr_d = {bit_v, sr_q[7:1]};
                        bits_d = bits_q + 3'd1;
                        data_d = (bits_q == 3'd7) ? sr_d : data_q;
                        valid_d = bits_q == 3'd7;
                    end
                end
            end
            EOP: if (smp) begin
                if (!eop2_q && line_q == LS_SE0) eop2_d = 1'b1;
                else if (eop2_q && line_q == LS_J) begin
                    state_d = IDLE;
                    prev_d = 1'b1;
                    active_d = 1'b0;
                    eop_d = 1'b1;
                    err_d = part_q;
                end else state_d = ERR;
            end
            ERR: begin
                jcnt_d = (line_q == LS_J) ? jcnt_q + 1'b1 : '0;
                state_d = (line_q == LS_J && jcnt_q == REC_LAST) ? IDLE : ERR;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ERR && state_q != ERR) begin
            err_d = 1'b1;
            active_d = 1'b0;
            jcnt_d = '0;
        end
        if (br_d) begin
            state_d = IDLE;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clock48) begin
        if (reset) begin
            sync1_q  <= LS_J;
            line_q   <= LS_J;
            phase_q  <= 2'd0;
            state_q  <= IDLE;
            prev_q   <= 1'b1;
            sr_q     <= '0;
            cnt_q    <= '0;
            bits_q   <= '0;
            ones_q   <= '0;
            eop2_q   <= 1'b0;
            part_q   <= 1'b0;
            jcnt_q   <= '0;
            data_q   <= '0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            eop_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= {usb_d_p, usb_d_n};
            line_q   <= sync1_q;
            phase_q  <= (sync1_q != line_q) ? 2'd0 : phase_q + 2'd1;
            state_q  <= state_d;
            prev_q   <= prev_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            ones_q   <= ones_d;
            eop2_q   <= eop2_d;
            part_q   <= part_d;
            jcnt_q   <= jcnt_d;
            data_q   <= data_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            eop_q    <= eop_d;
            err_q    <= err_d;
        end
    end

    assign rx_data = data_q;
    assign rx_valid = valid_q;
    assign rx_active = active_q;
    assign rx_eop = eop_q;
    assign rx_error = err_q;
endmodule

// File: tb/tb_usb_rx_line.sv
// tb_usb_rx_line: packet vectors encoded on the fly (NRZI + bit stuffing), strobes collected and compared.
module tb_usb_rx_line;
    typedef struct {
        logic [31:0] b;
        int n;
        int extra;
        bit nostuff;
        bit jit;
        int exp_n;
        int exp_eop;
        int exp_err;
        int exp_both;
    } vec_t;

`ifdef USB_RX_BUS_RESET_EN
    localparam int BR_EXP = 1;
`else
    localparam int BR_EXP = 0;
`endif

    logic clock48 = 1'b0;
    logic reset, usb_d_p, usb_d_n;
    logic [7:0] rx_data;
    logic rx_valid, rx_active, rx_eop, rx_error, bus_reset;
    int checks = 0;
    int errors = 0;
    int n_eop, n_err, n_both, n_act;
    logic [7:0] tx_q[$];
    logic [7:0] got_q[$];
    logic [1:0] sym_q[$];

    usb_rx_line dut (
        .clock48(clock48), .reset(reset), .usb_d_p(usb_d_p), .usb_d_n(usb_d_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
        .rx_eop(rx_eop), .rx_error(rx_error), .bus_reset(bus_reset)
    );

    always #10 clock48 = ~clock48;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clock48) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            check("active_with_valid", int'(rx_active), 1);
        end
        if (rx_eop) begin
            n_eop++;
            check("eop_valid_exclusive", int'(rx_valid), 0);
            check("active_drop_eop", int'(rx_active), 0);
        end
        if (rx_error) begin
            n_err++;
            check("active_drop_err", int'(rx_active), 0);
        end
        if (rx_eop && rx_error) n_both++;
        if (rx_active) n_act++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock48);
            #1;
        end
    endtask

    task automatic put(input logic [1:0] s, input int n);
        {usb_d_p, usb_d_n} = s;
        tick(n);
    endtask

    task automatic clear_mon();
        got_q.delete();
        n_eop = 0;
        n_err = 0;
        n_both = 0;
        n_act = 0;
    endtask

    // NRZI: a 0 is a level change, a 1 holds the level; a 0 is stuffed after six 1s
    task automatic emit(inout logic lvl, input logic b);
        if (!b) lvl = ~lvl;
        sym_q.push_back({lvl, ~lvl});
    endtask

    task automatic build(input int extra, input bit nostuff);
        logic lvl;
        int ones;
        logic [7:0] sync_bits;
        lvl = 1'b1;
        ones = 0;
        sync_bits = 8'h80;
        sym_q.delete();
        for (int i = 0; i < 8; i++) emit(lvl, sync_bits[i]);
        foreach (tx_q[j]) begin
            for (int i = 0; i < 8; i++) begin
                emit(lvl, tx_q[j][i]);
                ones = tx_q[j][i] ? ones + 1 : 0;
                if (ones == 6 && !nostuff) begin
                    emit(lvl, 1'b0);
                    ones = 0;
                end
            end
        end
        for (int i = 0; i < extra; i++) emit(lvl, (i % 2) == 0);
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b10);
    endtask

    task automatic drive(input int count, input bit jit);
        for (int i = 0; i < count; i++) put(sym_q[i], jit ? (((i % 2) != 0) ? 3 : 5) : 4);
    endtask

    task automatic run_vec(input vec_t v);
        tx_q.delete();
        for (int i = 0; i < v.n; i++) tx_q.push_back(v.b[8*i +: 8]);
        build(v.extra, v.nostuff);
        clear_mon();
        drive(sym_q.size(), v.jit);
        put(2'b10, 24);
        check("byte_count", got_q.size(), v.exp_n);
        for (int i = 0; i < got_q.size() && i < v.exp_n; i++)
            check("rx_data", int'(got_q[i]), int'(v.b[8*i +: 8]));
        check("eop_count", n_eop, v.exp_eop);
        check("err_count", n_err, v.exp_err);
        check("eop_err_same_cycle", n_both, v.exp_both);
        check("active_seen", int'(n_act > 0), 1);
        check("active_end", int'(rx_active), 0);
    endtask

    initial begin
        vec_t tbl[6];
        reset = 1'b1;
        {usb_d_p, usb_d_n} = 2'b10;
        tbl[0] = '{32'h000000A5, 1, 0, 1'b0, 1'b0, 1, 1, 0, 0};
        tbl[1] = '{32'h000001FF, 2, 0, 1'b0, 1'b0, 2, 1, 0, 0};
        tbl[2] = '{32'h0000003C, 1, 3, 1'b0, 1'b0, 1, 1, 1, 1};
        tbl[3] = '{32'h0000005A, 1, 0, 1'b0, 1'b1, 1, 1, 0, 0};
        tbl[4] = '{32'h000000FF, 1, 0, 1'b1, 1'b0, 0, 0, 1, 0};
        tbl[5] = '{32'h00007E00, 2, 0, 1'b0, 1'b1, 2, 1, 0, 0};
        tick(4);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_active", int'(rx_active), 0);
        check("reset_rx_eop", int'(rx_eop), 0);
        check("reset_rx_error", int'(rx_error), 0);
        check("reset_bus_reset", int'(bus_reset), 0);
        reset = 1'b0;
        tick(16);
        for (int t = 0; t < 6; t++) run_vec(tbl[t]);
        // seven ones without a stuff bit, then the minimum J gap before the next SYNC
        tx_q.delete();
        tx_q.push_back(8'h7F);
        build(0, 1'b1);
        clear_mon();
        drive(15, 1'b0);
        put(2'b10, 10);
        check("seven_ones_err", n_err, 1);
        check("seven_ones_active", int'(rx_active), 0);
        tx_q.delete();
        tx_q.push_back(8'hA5);
        build(0, 1'b0);
        drive(sym_q.size(), 1'b0);
        put(2'b10, 24);
        check("resync_bytes", got_q.size(), 1);
        if (got_q.size() > 0) check("resync_data", int'(got_q[0]), 'hA5);
        check("resync_eop", n_eop, 1);
        check("resync_err", n_err, 1);
        // reset in the middle of a packet
        tx_q.delete();
        tx_q.push_back(8'hC3);
        build(0, 1'b0);
        clear_mon();
        drive(12, 1'b0);
        check("active_mid_packet", int'(rx_active), 1);
        {usb_d_p, usb_d_n} = 2'b10;
        reset = 1'b1;
        tick(2);
        check("reset_mid_active", int'(rx_active), 0);
        check("reset_mid_data", int'(rx_data), 0);
        reset = 1'b0;
        tick(20);
        check("reset_mid_eop", n_eop, 0);
        check("reset_mid_err", n_err, 0);
        check("reset_mid_bytes", got_q.size(), 0);
        // long SE0
        clear_mon();
        put(2'b00, 119);
        check("bus_reset_early", int'(bus_reset), 0);
        put(2'b00, 6);
        check("bus_reset_set", int'(bus_reset), BR_EXP);
        put(2'b00, 75);
        check("bus_reset_hold", int'(bus_reset), BR_EXP);
        check("bus_reset_active", int'(rx_active), 0);
        put(2'b10, 4);
        check("bus_reset_clear", int'(bus_reset), 0);
        check("bus_reset_err", n_err, 0);
        check("bus_reset_eop", n_eop, 0);
        put(2'b10, 16);
        for (int r = 0; r < 16; r++) begin
            vec_t v;
            v.n = int'($urandom_range(1, 4));
            v.b = $urandom;
            v.extra = 0;
            v.nostuff = 1'b0;
            v.jit = 1'($urandom_range(0, 1));
            v.exp_n = v.n;
            v.exp_eop = 1;
            v.exp_err = 0;
            v.exp_both = 0;
            run_vec(v);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
